// File: rtl/ha_bist_checker.sv
// ha_bist_checker
//   On-chip stimulus/response checker for a half adder. It walks the
//   exhaustive vector set (a,b) = 11, 10, 01, 00 for NUM_PASSES sweeps.
//   Each vector is held for SETTLE_CYCLES WAIT cycles before the adder
//   outputs are compared with s = a^b, c = a&b. Mismatches are counted
//   in a saturating counter.
//
// Parameters
//   SETTLE_CYCLES : WAIT cycles per vector (1..15)
//   NUM_PASSES    : full 4-vector sweeps per start (1..15)
//   ERR_W         : width of err_count
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   start          in   level; sampled only in IDLE or DONE
//   dut_a, dut_b   out  registered half-adder inputs
//   dut_s, dut_c   in   half-adder sum / carry, sampled only in CHECK
//   busy           out  high in APPLY/WAIT/CHECK
//   done           out  high in DONE, sticky until the next start
//   pass           out  done && err_count == 0
//   err_count      out  mismatching vectors, saturates at all-ones
//
// Optional build macro HA_BIST_FIRST_FAIL_EN adds:
//   first_fail_idx out  vector index of the first mismatch since start
//   first_fail_obs out  observed {s,c} at that mismatch
module ha_bist_checker #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned NUM_PASSES    = 1,
    parameter int unsigned ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             dut_a,
    output logic             dut_b,
    input  logic             dut_s,
    input  logic             dut_c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count
`ifdef HA_BIST_FIRST_FAIL_EN
    ,
    output logic [1:0]       first_fail_idx,
    output logic [1:0]       first_fail_obs
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [3:0] LP_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] LP_PASS_LAST   = 4'(NUM_PASSES - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [1:0]       r_idx;
    logic [3:0]       r_pass_cnt;
    logic [3:0]       r_wait_cnt;
    logic             r_dut_a;
    logic             r_dut_b;
    logic [ERR_W-1:0] r_err;

    logic             w_start_ok;
    logic             w_mismatch;
    logic             w_last_vec;
    logic             w_last_pass;
    logic [1:0]       w_idx_inc;

    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last_vec  = (r_idx == 2'd3);
    assign w_last_pass = (r_pass_cnt == LP_PASS_LAST);
    assign w_idx_inc   = r_idx + 2'd1;
    // The vector currently on dut_a/dut_b is the reference for the compare.
    assign w_mismatch  = (r_state == S_CHECK) &&
                         ((dut_s != (r_dut_a ^ r_dut_b)) || (dut_c != (r_dut_a & r_dut_b)));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next_state = S_APPLY;
            S_APPLY:        w_next_state = S_WAIT;
            S_WAIT:         if (r_wait_cnt == '0) w_next_state = S_CHECK;
            S_CHECK:        w_next_state = (w_last_vec && w_last_pass) ? S_DONE : S_APPLY;
            default:        w_next_state = S_IDLE;
        endcase
    end

    // Sequencing datapath. Vector order 11,10,01,00 is simply {a,b} = ~index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_pass_cnt <= '0;
            r_wait_cnt <= '0;
            r_dut_a    <= 1'b0;
            r_dut_b    <= 1'b0;
            r_err      <= '0;
        end else begin
            if (w_start_ok) begin
                r_idx      <= '0;
                r_pass_cnt <= '0;
                r_err      <= '0;
                r_dut_a    <= 1'b1;
                r_dut_b    <= 1'b1;
            end
            if (r_state == S_APPLY) begin
                r_wait_cnt <= LP_SETTLE_LAST;
            end
            if ((r_state == S_WAIT) && (r_wait_cnt != '0)) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
            if (r_state == S_CHECK) begin
                if (w_mismatch && (r_err != '1)) begin
                    r_err <= r_err + ERR_W'(1);
                end
                if (!w_last_vec) begin
                    r_idx   <= w_idx_inc;
                    r_dut_a <= ~w_idx_inc[1];
                    r_dut_b <= ~w_idx_inc[0];
                end else if (!w_last_pass) begin
                    r_pass_cnt <= r_pass_cnt + 4'd1;
                    r_idx      <= '0;
                    r_dut_a    <= 1'b1;
                    r_dut_b    <= 1'b1;
                end
            end
        end
    end

`ifdef HA_BIST_FIRST_FAIL_EN
    logic       r_ff_seen;
    logic [1:0] r_ff_idx;
    logic [1:0] r_ff_obs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ff_seen <= 1'b0;
            r_ff_idx  <= '0;
            r_ff_obs  <= '0;
        end else if (w_start_ok) begin
            r_ff_seen <= 1'b0;
            r_ff_idx  <= '0;
            r_ff_obs  <= '0;
        end else if (w_mismatch && !r_ff_seen) begin
            r_ff_seen <= 1'b1;
            r_ff_idx  <= r_idx;
            r_ff_obs  <= {dut_s, dut_c};
        end
    end

    assign first_fail_idx = r_ff_idx;
    assign first_fail_obs = r_ff_obs;
`endif

    assign dut_a     = r_dut_a;
    assign dut_b     = r_dut_b;
    assign busy      = (r_state == S_APPLY) || (r_state == S_WAIT) || (r_state == S_CHECK);
    assign done      = (r_state == S_DONE);
    assign pass      = (r_state == S_DONE) && (r_err == '0);
    assign err_count = r_err;

endmodule

// File: tb/tb_ha_bist_checker.sv
module tb_ha_bist_checker;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic sel;                       // 0: default instance, 1: SETTLE=3/NUM_PASSES=4 instance
    logic [3:0] fs;                  // sum flip mask, indexed by {a,b}
    logic [3:0] fc;                  // carry flip mask, indexed by {a,b}
    logic noise_en, noise_s, noise_c;

    logic a1, b1, s1, c1, busy1, done1, pass1;
    logic a2, b2, s2, c2, busy2, done2, pass2;
    logic [3:0] err1, err2;
    logic start1, start2;

    logic oa, ob, obusy, odone, opass;
    logic [3:0] oerr;

    logic [1:0] VEC [4] = '{2'b11, 2'b10, 2'b01, 2'b00};

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    // Half adder under test, with per-vector fault injection and optional noise.
    always_comb begin
        s1 = (a1 ^ b1) ^ fs[{a1, b1}];
        c1 = (a1 & b1) ^ fc[{a1, b1}];
        s2 = (a2 ^ b2) ^ fs[{a2, b2}];
        c2 = (a2 & b2) ^ fc[{a2, b2}];
        if (noise_en) begin
            s1 = noise_s; c1 = noise_c;
            s2 = noise_s; c2 = noise_c;
        end
    end

    assign start1 = start && !sel;
    assign start2 = start && sel;
    assign oa    = sel ? a2 : a1;
    assign ob    = sel ? b2 : b1;
    assign obusy = sel ? busy2 : busy1;
    assign odone = sel ? done2 : done1;
    assign opass = sel ? pass2 : pass1;
    assign oerr  = sel ? err2 : err1;

`ifdef HA_BIST_FIRST_FAIL_EN
    logic [1:0] ffi1, ffo1, ffi2, ffo2, offi, offo;
    assign offi = sel ? ffi2 : ffi1;
    assign offo = sel ? ffo2 : ffo1;
`endif

    ha_bist_checker u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .dut_a(a1), .dut_b(b1), .dut_s(s1), .dut_c(c1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1)
`ifdef HA_BIST_FIRST_FAIL_EN
        , .first_fail_idx(ffi1), .first_fail_obs(ffo1)
`endif
    );

    ha_bist_checker #(.SETTLE_CYCLES(3), .NUM_PASSES(4), .ERR_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .dut_a(a2), .dut_b(b2), .dut_s(s2), .dut_c(c2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2)
`ifdef HA_BIST_FIRST_FAIL_EN
        , .first_fail_idx(ffi2), .first_fail_obs(ffo2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Number of sweep-order vectors among the first m checks that mismatch, saturated.
    function automatic int unsigned exp_err(input int unsigned m);
        int unsigned n = 0;
        for (int unsigned j = 0; j < m; j++)
            if (fs[VEC[j % 4]] || fc[VEC[j % 4]]) n++;
        return (n > 15) ? 15 : n;
    endfunction

    function automatic logic [3:0] exp_first_fail();
        logic [1:0] v;
        for (int unsigned j = 0; j < 4; j++) begin
            v = VEC[j];
            if (fs[v] || fc[v])
                return {2'(j), (v[1] ^ v[0]) ^ fs[v], (v[1] & v[0]) ^ fc[v]};
        end
        return 4'b0000;
    endfunction

    task automatic check_idle_zero(input string tag);
        chk({tag, "_a"}, 32'(oa), 0);
        chk({tag, "_b"}, 32'(ob), 0);
        chk({tag, "_busy"}, 32'(obusy), 0);
        chk({tag, "_done"}, 32'(odone), 0);
        chk({tag, "_pass"}, 32'(opass), 0);
        chk({tag, "_err"}, 32'(oerr), 0);
`ifdef HA_BIST_FIRST_FAIL_EN
        chk({tag, "_ffidx"}, 32'(offi), 0);
        chk({tag, "_ffobs"}, 32'(offo), 0);
`endif
    endtask

    // One full sweep on the selected instance; checks every cycle and the final state.
    task automatic sweep(input logic use2, input logic hold, input logic noisy);
        int unsigned S, P, L, T, e;
        logic [1:0] v;
        logic [3:0] ff;
        sel = use2;
        S = use2 ? 3 : 1;
        P = use2 ? 4 : 1;
        L = S + 2;
        T = 4 * P * L;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int unsigned k = 0; k < T; k++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            v = VEC[(k / L) % 4];
            chk("vec_a", 32'(oa), 32'(v[1]));
            chk("vec_b", 32'(ob), 32'(v[0]));
            chk("busy", 32'(obusy), 1);
            chk("done_low", 32'(odone), 0);
            chk("err_run", 32'(oerr), exp_err(k / L));
            if (noisy && ((k % L) != (L - 1))) begin
                noise_en = 1'b1;
                noise_s = 1'($urandom);
                noise_c = 1'($urandom);
            end else begin
                noise_en = 1'b0;
            end
        end
        @(negedge clk);
        noise_en = 1'b0;
        e = exp_err(4 * P);
        chk("done", 32'(odone), 1);
        chk("busy_end", 32'(obusy), 0);
        chk("err_end", 32'(oerr), e);
        chk("pass_end", 32'(opass), (e == 0) ? 1 : 0);
        chk("end_a", 32'(oa), 0);
        chk("end_b", 32'(ob), 0);
        ff = exp_first_fail();
`ifdef HA_BIST_FIRST_FAIL_EN
        chk("ff_idx", 32'(offi), 32'(ff[3:2]));
        chk("ff_obs", 32'(offo), 32'(ff[1:0]));
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; start = 1'b0; sel = 1'b0;
        fs = '0; fc = '0;
        noise_en = 1'b0; noise_s = 1'b0; noise_c = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        sel = 1'b0; check_idle_zero("rst1");
        sel = 1'b1; check_idle_zero("rst2");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Correct adder, defaults
        fs = '0; fc = '0;
        sweep(1'b0, 1'b0, 1'b0);

        // Carry stuck at 0: only vector 11 is affected
        fs = '0; fc = 4'b1000;
        sweep(1'b0, 1'b0, 1'b0);

        // Sum inverted over 4 passes: 16 mismatches saturate at 15
        fs = 4'b1111; fc = '0;
        sweep(1'b1, 1'b0, 1'b0);

        // Correct adder, SETTLE=3, outputs toggled outside CHECK
        fs = '0; fc = '0;
        sweep(1'b1, 1'b0, 1'b1);

        // Asynchronous reset during WAIT of vector 2
        sel = 1'b0; fs = 4'b0110; fc = '0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_rst_busy", 32'(obusy), 1);
        chk("pre_rst_a", 32'(oa), 0);
        chk("pre_rst_b", 32'(ob), 1);
        #1 rst_n = 1'b0;
        #1 check_idle_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        check_idle_zero("after_rst");
        fs = '0; fc = '0;
        sweep(1'b0, 1'b0, 1'b0);

        // start held high: no restart while busy, immediate restart from DONE
        fs = '0; fc = 4'b0001;
        sweep(1'b0, 1'b1, 1'b0);
        fs = '0; fc = '0;
        @(negedge clk);
        chk("restart_busy", 32'(obusy), 1);
        chk("restart_done", 32'(odone), 0);
        chk("restart_err", 32'(oerr), 0);
        chk("restart_a", 32'(oa), 1);
        chk("restart_b", 32'(ob), 1);
        start = 1'b0;
        for (int unsigned i = 0; i < 100 && !odone; i++) @(negedge clk);
        chk("restart_fin_done", 32'(odone), 1);
        chk("restart_fin_pass", 32'(opass), 1);
        chk("restart_fin_err", 32'(oerr), 0);
`ifdef HA_BIST_FIRST_FAIL_EN
        chk("restart_ffidx", 32'(offi), 0);
        chk("restart_ffobs", 32'(offo), 0);
`endif

        // Randomized fault patterns on both configurations
        for (int unsigned r = 0; r < 8; r++) begin
            fs = 4'($urandom);
            fc = 4'($urandom);
            sweep(1'($urandom), 1'b0, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
